// File: rtl/word_serializer.sv
// Parallel-to-serial framer: sends a WIDTH-bit word LSB byte first to a UART
// transmitter, then an XOR checksum byte, with a ready/taken handshake per byte.
module word_serializer #(
  parameter int WIDTH  = 368,
  parameter int NBYTES = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] x,
  input  logic             tx_ready,
  output logic             tx_new_byte,
  output logic [7:0]       tx_byte,
  output logic             busy,
  output logic             dn
);

  localparam int CW = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [7:0]       csum;
  logic             taken;
  logic             csum_sent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      csum        <= 8'h00;
      taken       <= 1'b0;
      csum_sent   <= 1'b0;
      tx_new_byte <= 1'b0;
      tx_byte     <= 8'h00;
      busy        <= 1'b0;
      dn          <= 1'b0;
    end else begin
      tx_new_byte <= 1'b0;
      dn          <= 1'b0;
      case (state)
        IDLE: begin
          if (ld) begin
            shreg     <= x;
            cnt       <= '0;
            csum      <= 8'h00;
            csum_sent <= 1'b0;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            // Once every data byte has gone out, the next byte is the checksum.
            if (cnt == CW'(NBYTES)) begin
              tx_byte   <= csum;
              csum_sent <= 1'b1;
            end else begin
              tx_byte <= shreg[7:0];
              csum    <= csum ^ shreg[7:0];
              shreg   <= shreg >> 8;
              cnt     <= cnt + CW'(1);
            end
            tx_new_byte <= 1'b1;
            taken       <= 1'b0;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (!tx_ready) begin
            taken <= 1'b1;
          end else if (taken) begin
            if (csum_sent) begin
              dn    <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              state <= SEND;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: 16-bit and 368-bit instances, each driven
// by a transmitter model that holds tx_ready low for 10 cycles per byte.
module tb_word_serializer;

  logic clk;
  logic rst_n;

  logic        ld16, hold16, rdy16, tx_ready16, tx_new_byte16, busy16, dn16;
  logic [15:0] x16;
  logic [7:0]  tx_byte16;

  logic         ld368, rdy368, tx_ready368, tx_new_byte368, busy368, dn368;
  logic [367:0] x368;
  logic [7:0]   tx_byte368;

  int checks = 0;
  int errors = 0;

  logic [7:0] q16[$];
  logic [7:0] q368[$];
  int dn_cnt16 = 0, dn_cnt368 = 0, overlap = 0;
  int cnt16 = 0, cnt368 = 0;

  assign tx_ready16  = rdy16 && !hold16;
  assign tx_ready368 = rdy368;

  word_serializer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .ld(ld16), .x(x16), .tx_ready(tx_ready16),
    .tx_new_byte(tx_new_byte16), .tx_byte(tx_byte16), .busy(busy16), .dn(dn16)
  );

  word_serializer #(.WIDTH(368)) dut368 (
    .clk(clk), .rst_n(rst_n), .ld(ld368), .x(x368), .tx_ready(tx_ready368),
    .tx_new_byte(tx_new_byte368), .tx_byte(tx_byte368), .busy(busy368), .dn(dn368)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter models: a strobe makes the UART busy for 10 cycles.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt16 = 0;
    end else begin
      if (cnt16 > 0) cnt16--;
      if (tx_new_byte16) begin
        q16.push_back(tx_byte16);
        cnt16 = 10;
      end
      if (dn16) dn_cnt16++;
      if (dn16 && tx_new_byte16) overlap++;
    end
    rdy16 = (cnt16 == 0);
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt368 = 0;
    end else begin
      if (cnt368 > 0) cnt368--;
      if (tx_new_byte368) begin
        q368.push_back(tx_byte368);
        cnt368 = 10;
      end
      if (dn368) dn_cnt368++;
      if (dn368 && tx_new_byte368) overlap++;
    end
    rdy368 = (cnt368 == 0);
  end

  typedef struct {
    logic [15:0] x;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  ck;
  } vec_t;

  vec_t vt[5];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_dn16(input int start, input string name);
    int n = 0;
    while (dn_cnt16 == start && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_dn_seen"}, 32'(dn_cnt16 != start), 32'd1);
  endtask

  task automatic wait_dn368(input int start, input string name);
    int n = 0;
    while (dn_cnt368 == start && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_dn_seen"}, 32'(dn_cnt368 != start), 32'd1);
  endtask

  task automatic load16(input logic [15:0] val);
    x16  = val;
    ld16 = 1'b1;
    tick();
    ld16 = 1'b0;
  endtask

  task automatic check_frame16(input string name, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] ck);
    chk({name, "_nbytes"}, 32'(q16.size()), 32'd3);
    if (q16.size() == 3) begin
      chk({name, "_b0"}, 32'(q16[0]), 32'(b0));
      chk({name, "_b1"}, 32'(q16[1]), 32'(b1));
      chk({name, "_ck"}, 32'(q16[2]), 32'(ck));
    end
  endtask

  initial begin
    int start;
    int nbad;
    int n;
    logic [7:0] ck;

    vt[0] = '{16'hA55A, 8'h5A, 8'hA5, 8'hFF};
    vt[1] = '{16'h1234, 8'h34, 8'h12, 8'h26};
    vt[2] = '{16'h00FF, 8'hFF, 8'h00, 8'hFF};
    vt[3] = '{16'h0000, 8'h00, 8'h00, 8'h00};
    vt[4] = '{16'h8001, 8'h01, 8'h80, 8'h81};

    rst_n = 1'b1; ld16 = 1'b0; hold16 = 1'b0; x16 = '0; ld368 = 1'b0; x368 = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tx_byte", 32'(tx_byte16), 32'h0);
    chk("rst_strobe", 32'(tx_new_byte16), 32'h0);
    chk("rst_busy", 32'(busy16), 32'h0);
    chk("rst_dn", 32'(dn16), 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Table-driven 16-bit frames
    for (int i = 0; i < 5; i++) begin
      q16.delete();
      start = dn_cnt16;
      load16(vt[i].x);
      chk($sformatf("vec%0d_busy", i), 32'(busy16), 32'd1);
      wait_dn16(start, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_busy_at_dn", i), 32'(busy16), 32'd0);
      tick();
      chk($sformatf("vec%0d_dn_once", i), 32'(dn_cnt16 - start), 32'd1);
      check_frame16($sformatf("vec%0d", i), vt[i].b0, vt[i].b1, vt[i].ck);
      repeat (3) tick();
    end

    // Transmitter stalled for 100 cycles after load
    q16.delete();
    hold16 = 1'b1;
    start = dn_cnt16;
    load16(16'hC33C);
    repeat (100) tick();
    chk("stall_no_strobe", 32'(q16.size()), 32'd0);
    chk("stall_busy", 32'(busy16), 32'd1);
    hold16 = 1'b0;
    tick();
    chk("stall_release_strobe", 32'(tx_new_byte16), 32'd1);
    chk("stall_release_byte", 32'(tx_byte16), 32'h3C);
    wait_dn16(start, "stall");
    tick();
    check_frame16("stall", 8'h3C, 8'hC3, 8'hFF);

    // ld while busy is ignored
    q16.delete();
    start = dn_cnt16;
    load16(16'h1234);
    n = 0;
    while (q16.size() < 1 && n < 100) begin tick(); n++; end
    load16(16'hFFFF);
    wait_dn16(start, "ld_busy");
    tick();
    check_frame16("ld_busy", 8'h34, 8'h12, 8'h26);
    repeat (3) tick();

    // Asynchronous reset after the second strobe aborts the frame
    q16.delete();
    start = dn_cnt16;
    load16(16'hA55A);
    n = 0;
    while (q16.size() < 2 && n < 200) begin tick(); n++; end
    chk("abort_two_bytes", 32'(q16.size()), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rst_strobe", 32'(tx_new_byte16), 32'h0);
    chk("abort_rst_byte", 32'(tx_byte16), 32'h0);
    chk("abort_rst_busy", 32'(busy16), 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (60) tick();
    chk("abort_no_third", 32'(q16.size()), 32'd2);
    chk("abort_no_dn", 32'(dn_cnt16 - start), 32'd0);
    q16.delete();
    start = dn_cnt16;
    load16(16'hA55A);
    wait_dn16(start, "after_abort");
    tick();
    check_frame16("after_abort", 8'h5A, 8'hA5, 8'hFF);
    repeat (3) tick();

    // ld held high: back-to-back frames separated by DONE and IDLE
    q16.delete();
    start = dn_cnt16;
    x16  = 16'h00FF;
    ld16 = 1'b1;
    wait_dn16(start, "b2b_f1");
    chk("b2b_busy_done", 32'(busy16), 32'd0);
    tick();
    chk("b2b_busy_idle", 32'(busy16), 32'd0);
    tick();
    chk("b2b_busy_next", 32'(busy16), 32'd1);
    wait_dn16(start + 1, "b2b_f2");
    ld16 = 1'b0;
    repeat (5) tick();
    chk("b2b_dn_count", 32'(dn_cnt16 - start), 32'd2);
    chk("b2b_bytes", 32'(q16.size()), 32'd6);
    chk("b2b_idle_after", 32'(busy16), 32'd0);

    // 368-bit all-ones word
    q368.delete();
    start = dn_cnt368;
    x368 = '1;
    ld368 = 1'b1;
    tick();
    ld368 = 1'b0;
    wait_dn368(start, "ones368");
    repeat (3) tick();
    chk("ones368_nbytes", 32'(q368.size()), 32'd47);
    nbad = 0;
    for (int i = 0; i < q368.size(); i++)
      if (q368[i] !== ((i == 46) ? 8'h00 : 8'hFF)) nbad++;
    chk("ones368_bytes", 32'(nbad), 32'd0);
    chk("ones368_dn_once", 32'(dn_cnt368 - start), 32'd1);

    // 368-bit ramp checks byte order
    q368.delete();
    start = dn_cnt368;
    ck = 8'h00;
    for (int i = 0; i < 46; i++) begin
      x368[i*8 +: 8] = 8'(i);
      ck = ck ^ 8'(i);
    end
    ld368 = 1'b1;
    tick();
    ld368 = 1'b0;
    wait_dn368(start, "ramp368");
    repeat (3) tick();
    chk("ramp368_nbytes", 32'(q368.size()), 32'd47);
    nbad = 0;
    for (int i = 0; i < q368.size(); i++)
      if (q368[i] !== ((i == 46) ? ck : 8'(i))) nbad++;
    chk("ramp368_bytes", 32'(nbad), 32'd0);

    chk("no_dn_strobe_overlap", 32'(overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
